vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync_pkg.sv | 33 +++
 rtl/pix_div.sv | 17 +
 rtl/vga_sync.sv | 109 ++++++++++
 tb/tb_vga_sync.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/vga_sync_pkg.sv
// Shared VGA timing defaults, counter widths and sync polarity for vga_sync.
package vga_sync_pkg;

  localparam int unsigned CNT_W       = 11;
  localparam int unsigned FRAME_CNT_W = 16;

  // 640x480 @ 60 Hz industry timing
  localparam int unsigned HLINES      = 640;
  localparam int unsigned H_FRONT_DEF = 16;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned H_BACK_DEF  = 48;
  localparam int unsigned VLINES      = 480;
  localparam int unsigned V_FRONT_DEF = 10;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned V_BACK_DEF  = 33;

  localparam logic SYNC_ACTIVE = 1'b0;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
    logic blank;
  } vga_timing_t;

  function automatic logic in_range(input logic [CNT_W-1:0] x,
                                    input logic [CNT_W-1:0] lo,
                                    input logic [CNT_W-1:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

endpackage

// File: rtl/pix_div.sv
// Divide-by-two pixel enable: a toggling bit that is high every second clk.
module pix_div (
  input  logic clk,
  input  logic rst_n,
  output logic pix_en
);

  logic div_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_q <= 1'b0;
    else        div_q <= ~div_q;
  end

  assign pix_en = div_q;

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing generator with zero-lag registered sync/blank outputs.
// Optional frame counter output enabled by defining VGA_FRAME_CNT_EN.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int unsigned H_VISIBLE = HLINES,
  parameter int unsigned H_FRONT   = H_FRONT_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BACK    = H_BACK_DEF,
  parameter int unsigned V_VISIBLE = VLINES,
  parameter int unsigned V_FRONT   = V_FRONT_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BACK    = V_BACK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_en,
  output logic [CNT_W-1:0] hcount,
  output logic [CNT_W-1:0] vcount,
  output logic             hsync,
  output logic             vsync,
  output logic             hblank,
  output logic             vblank,
  output logic             blank,
  output logic             frame_tick
`ifdef VGA_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] frame_cnt
`endif
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  localparam vga_timing_t TIMING_RST = '{hsync: ~SYNC_ACTIVE, vsync: ~SYNC_ACTIVE,
                                         hblank: 1'b0, vblank: 1'b0, blank: 1'b0};

  logic             h_wrap;
  logic             v_wrap;
  logic [CNT_W-1:0] h_nxt;
  logic [CNT_W-1:0] v_nxt;
  logic             tick_nxt;
  vga_timing_t      tmg_nxt;
  vga_timing_t      tmg_q;

  pix_div u_pix_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en)
  );

  // Next raster position and the timing it implies, so flops land aligned with counts
  always_comb begin
    h_wrap   = (hcount == H_LAST);
    v_wrap   = (vcount == V_LAST);
    h_nxt    = h_wrap ? '0 : hcount + CNT_W'(1);
    v_nxt    = vcount;
    if (h_wrap) v_nxt = v_wrap ? '0 : vcount + CNT_W'(1);

    tmg_nxt        = TIMING_RST;
    tmg_nxt.hsync  = in_range(h_nxt, HS_START, HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tmg_nxt.vsync  = in_range(v_nxt, VS_START, VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    tmg_nxt.hblank = (h_nxt >= H_VIS);
    tmg_nxt.vblank = (v_nxt >= V_VIS);
    tmg_nxt.blank  = tmg_nxt.hblank | tmg_nxt.vblank;

    tick_nxt = pix_en & h_wrap & v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount     <= '0;
      vcount     <= '0;
      tmg_q      <= TIMING_RST;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= tick_nxt;
      if (pix_en) begin
        hcount <= h_nxt;
        vcount <= v_nxt;
        tmg_q  <= tmg_nxt;
      end
    end
  end

  assign hsync  = tmg_q.hsync;
  assign vsync  = tmg_q.vsync;
  assign hblank = tmg_q.hblank;
  assign vblank = tmg_q.vblank;
  assign blank  = tmg_q.blank;

`ifdef VGA_FRAME_CNT_EN
  // Counts frame starts; wraps naturally at the register width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        frame_cnt <= '0;
    else if (tick_nxt) frame_cnt <= frame_cnt + FRAME_CNT_W'(1);
  end
`endif

endmodule

// File: tb/tb_vga_sync.sv
// Randomised scoreboard bench for vga_sync using a reduced raster so whole frames fit.
module tb_vga_sync;

  localparam int unsigned HV = 16, HF = 2, HS = 3, HB = 4;
  localparam int unsigned VV = 10, VF = 2, VS = 2, VB = 3;
  localparam int unsigned HT = HV + HF + HS + HB;
  localparam int unsigned VT = VV + VF + VS + VB;
  localparam int unsigned FRAME_PIX = HT * VT;
  localparam int unsigned N_CYCLES  = 5000;

  typedef struct {
    int unsigned pix_en, h, v, hs, vs, hb, vb, bl, ft, fc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        pix_en, hsync, vsync, hblank, vblank, blank, frame_tick;
  logic [10:0] hcount, vcount;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] frame_cnt;
`endif

  exp_t        sb_q[$];
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bit          drv_done = 0;

  vga_sync #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pix_en     (pix_en),
    .hcount     (hcount),
    .vcount     (vcount),
    .hsync      (hsync),
    .vsync      (vsync),
    .hblank     (hblank),
    .vblank     (vblank),
    .blank      (blank),
    .frame_tick (frame_tick)
`ifdef VGA_FRAME_CNT_EN
    ,
    .frame_cnt  (frame_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Expected outputs k clk edges after reset release: one pixel per two clks
  function automatic exp_t model(input int unsigned k);
    exp_t        e;
    int unsigned adv, p;
    adv      = k / 2;
    p        = adv % FRAME_PIX;
    e.pix_en = k % 2;
    e.h      = p % HT;
    e.v      = p / HT;
    e.hs     = (e.h >= HV + HF && e.h < HV + HF + HS) ? 0 : 1;
    e.vs     = (e.v >= VV + VF && e.v < VV + VF + VS) ? 0 : 1;
    e.hb     = (e.h >= HV) ? 1 : 0;
    e.vb     = (e.v >= VV) ? 1 : 0;
    e.bl     = (e.hb != 0 || e.vb != 0) ? 1 : 0;
    e.ft     = (k > 0 && k % 2 == 0 && p == 0) ? 1 : 0;
    e.fc     = (adv / FRAME_PIX) % 65536;
    return e;
  endfunction

  function automatic exp_t reset_exp();
    exp_t e;
    e = '{pix_en: 0, h: 0, v: 0, hs: 1, vs: 1, hb: 0, vb: 0, bl: 0, ft: 0, fc: 0};
    return e;
  endfunction

  task automatic chk(input string name, input int unsigned act, input int unsigned req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
  endtask

  // Driver: random async resets between edges, pushes the expectation for the next negedge
  initial begin
    int unsigned k;
    bit          in_rst;
    int unsigned rst_left;
    k        = 0;
    rst_n    = 1'b0;
    in_rst   = 1'b1;
    rst_left = 10;
    for (int c = 0; c < N_CYCLES; c++) begin
      @(posedge clk);
      if (rst_n) k++;
      #1;
      if (in_rst) begin
        if (rst_left == 0) begin
          rst_n  = 1'b1;
          in_rst = 1'b0;
          k      = 0;
        end else begin
          rst_left--;
        end
        sb_q.push_back(reset_exp());
      end else if (c == 2700 || (c > 2700 && $urandom_range(0, 599) == 0)) begin
        #1 rst_n = 1'b0;
        in_rst   = 1'b1;
        rst_left = $urandom_range(1, 4);
        sb_q.push_back(reset_exp());
      end else begin
        sb_q.push_back(model(k));
      end
    end
    drv_done = 1'b1;
  end

  // Monitor: compares DUT outputs against the queued expectation on each falling edge
  initial begin
    exp_t e;
    int   idle;
    idle = 0;
    forever begin
      @(negedge clk);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("pix_en",     pix_en,     e.pix_en);
        chk("hcount",     hcount,     e.h);
        chk("vcount",     vcount,     e.v);
        chk("hsync",      hsync,      e.hs);
        chk("vsync",      vsync,      e.vs);
        chk("hblank",     hblank,     e.hb);
        chk("vblank",     vblank,     e.vb);
        chk("blank",      blank,      e.bl);
        chk("frame_tick", frame_tick, e.ft);
`ifdef VGA_FRAME_CNT_EN
        chk("frame_cnt",  frame_cnt,  e.fc);
`endif
      end else if (drv_done) begin
        idle++;
        if (idle > 4) begin
          if (n_checks < 12) chk("check_volume", n_checks, 12);
          $display("%0d/%0d checks passed", n_pass, n_checks);
          $finish;
        end
      end
    end
  end

  // Watchdog so the run always ends
  initial begin
    #((N_CYCLES + 100) * 10);
    chk("watchdog", 1, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
